seq_alu: RTL and testbench

- Parametrised, handshaked successor to the combinational Hack-style ALU.
- Adds a registered result, valid/ready flow control on input and output, and three multi-cycle modes: iterative multiply, logical shift left, logical shift right.
- Sits between the register file/decoder and the writeback stage. Hack mode gives single-cycle latency with back-to-back throughput.

---
 rtl/seq_alu.sv | 198 +++++++++++++++++++
 tb/tb_seq_alu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle Hack datapath plus iterative
// multiply and bit-serial logical shifts, with a registered result and flags.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  CNT_W   = CNTW'(WIDTH);
    localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Hack datapath; returns {carry, result}, carry taken before the output inversion.
    function automatic logic [WIDTH:0] hack_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             za,
        input logic             na,
        input logic             zb,
        input logic             nb,
        input logic             fa,
        input logic             neg
    );
        logic [WIDTH-1:0] xa;
        logic [WIDTH-1:0] yb;
        logic [WIDTH-1:0] r;
        logic [WIDTH:0]   s;
        xa = za ? {WIDTH{1'b0}} : a;
        xa = na ? ~xa : xa;
        yb = zb ? {WIDTH{1'b0}} : b;
        yb = nb ? ~yb : yb;
        s  = {1'b0, xa} + {1'b0, yb};
        r  = fa ? s[WIDTH-1:0] : (xa & yb);
        r  = neg ? ~r : r;
        return {fa & s[WIDTH], r};
    endfunction

    state_t             state_r, state_s;
    logic [2*WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0]   mcand_r, mcand_s;
    logic [CNTW-1:0]    cnt_r, cnt_s;
    logic [1:0]         mode_r, mode_s;
    logic [WIDTH-1:0]   out_r, res_s;
    logic               zr_r, ng_r, cy_r, rcy_s, ld_s;
    logic               accept_s;
    logic [WIDTH:0]     hack_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_s;
    logic [CNTW-1:0]    amt_s;

    assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == DONE);
    assign out       = out_r;
    assign zr        = zr_r;
    assign ng        = ng_r;
    assign cy        = cy_r;

    assign hack_s = hack_f(x, y, zx, nx, zy, ny, f, no);
    assign amt_s  = CNTW'(y % WIDTH_V);
    // Shift-add step: upper half accumulates the multiplicand, low half holds the remaining multiplier bits.
    assign sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    assign mul_s  = acc_r[0] ? {sum_s, acc_r[WIDTH-1:1]} : {1'b0, acc_r[2*WIDTH-1:1]};

    // Next-state and datapath control.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        mcand_s = mcand_r;
        cnt_s   = cnt_r;
        mode_s  = mode_r;
        res_s   = out_r;
        rcy_s   = cy_r;
        ld_s    = 1'b0;
        if (accept_s) begin
            mode_s = mode;
            case (mode)
                2'b00: begin
                    res_s   = hack_s[WIDTH-1:0];
                    rcy_s   = hack_s[WIDTH];
                    ld_s    = 1'b1;
                    state_s = DONE;
                end
                2'b01: begin
                    acc_s   = {{WIDTH{1'b0}}, y};
                    mcand_s = x;
                    cnt_s   = CNT_W;
                    state_s = BUSY;
                end
                default: begin
                    if (amt_s == {CNTW{1'b0}}) begin
                        res_s   = x;
                        rcy_s   = 1'b0;
                        ld_s    = 1'b1;
                        state_s = DONE;
                    end else begin
                        acc_s   = {{WIDTH{1'b0}}, x};
                        cnt_s   = amt_s;
                        state_s = BUSY;
                    end
                end
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                BUSY: begin
                    cnt_s = cnt_r - CNT_ONE;
                    case (mode_r)
                        2'b01: begin
                            acc_s = mul_s;
                            rcy_s = |mul_s[2*WIDTH-1:WIDTH];
                        end
                        2'b10: begin
                            acc_s = {{WIDTH{1'b0}}, acc_r[WIDTH-2:0], 1'b0};
                            rcy_s = acc_r[WIDTH-1];
                        end
                        default: begin
                            acc_s = {{WIDTH{1'b0}}, 1'b0, acc_r[WIDTH-1:1]};
                            rcy_s = acc_r[0];
                        end
                    endcase
                    res_s = acc_s[WIDTH-1:0];
                    if (cnt_r == CNT_ONE) begin
                        ld_s    = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, working and result registers; flags load together with the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
            mode_r  <= 2'b00;
            out_r   <= {WIDTH{1'b0}};
            zr_r    <= 1'b0;
            ng_r    <= 1'b0;
            cy_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            mcand_r <= mcand_s;
            cnt_r   <= cnt_s;
            mode_r  <= mode_s;
            if (ld_s) begin
                out_r <= res_s;
                zr_r  <= (res_s == {WIDTH{1'b0}});
                ng_r  <= res_s[WIDTH-1];
                cy_r  <= rcy_s;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations are queued at accept and
// compared at the output handshake, with latency and handshake checks.
module tb_seq_alu;

    localparam int W = 16;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   mode;
    logic [W-1:0] x, y, out;
    logic         zx, nx, zy, ny, f, no, zr, ng, cy;

    typedef struct {
        logic [W-1:0] o;
        logic         zr;
        logic         ng;
        logic         cy;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_waits = 0;
    bit   head_seen = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny),
        .f(f), .no(no), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng), .cy(cy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] xv,
                                   input logic [W-1:0] yv, input logic [5:0] ctl);
        exp_t e;
        logic [W-1:0] a, b;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        int n;
        e.cy = 1'b0;
        e.lat = 1;
        case (m)
            2'b00: begin
                a = ctl[5] ? 16'h0000 : xv;
                if (ctl[4]) a = ~a;
                b = ctl[3] ? 16'h0000 : yv;
                if (ctl[2]) b = ~b;
                s = {1'b0, a} + {1'b0, b};
                if (ctl[1]) begin
                    e.o = s[W-1:0];
                    e.cy = s[W];
                end else begin
                    e.o = a & b;
                end
                if (ctl[0]) e.o = ~e.o;
            end
            2'b01: begin
                p = 32'(xv) * 32'(yv);
                e.o = p[W-1:0];
                e.cy = (p[2*W-1:W] != 16'h0000);
                e.lat = W + 1;
            end
            default: begin
                n = int'(yv) % W;
                if (n == 0) begin
                    e.o = xv;
                end else if (m == 2'b10) begin
                    e.o = xv << n;
                    e.cy = xv[W-n];
                    e.lat = n + 1;
                end else begin
                    e.o = xv >> n;
                    e.cy = xv[n-1];
                    e.lat = n + 1;
                end
            end
        endcase
        e.zr = (e.o == 16'h0000);
        e.ng = e.o[W-1];
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            head_seen = 0;
        end else begin
            if (out_valid && !head_seen) begin
                head_seen = 1;
                if (q.size() == 0) chk("spurious_valid", q.size(), 1);
                else chk("latency", cyc - q[0].acc, q[0].lat);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("out", out, e.o);
                chk("zr", zr, e.zr);
                chk("ng", ng, e.ng);
                chk("cy", cy, e.cy);
                head_seen = 0;
            end
            if (in_valid && in_ready) begin
                e = model(mode, x, y, {zx, nx, zy, ny, f, no});
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [W-1:0] xv,
                         input logic [W-1:0] yv, input logic [5:0] ctl);
        int waits;
        bit done;
        mode = m;
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = ctl;
        in_valid = 1'b1;
        waits = 0;
        done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) waits++;
        end
        if (!done) chk("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        last_waits = waits;
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (out_valid) begin
                done = 1;
            end else begin
                chk("busy_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("done_timeout", out_valid, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mode = 2'b00;
        x = 16'h0000;
        y = 16'h0000;
        {zx, nx, zy, ny, f, no} = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_flags", {zr, ng, cy}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Hack add, then back-to-back Hack ops.
        issue(2'b00, 16'd5, 16'd7, 6'b000010);
        chk("hack_valid_next", out_valid, 1);
        issue(2'b00, 16'd3, 16'd3, 6'b010011);
        chk("b2b_ready1", last_waits, 0);
        issue(2'b00, 16'd9, 16'd4, 6'b111010);
        chk("b2b_ready2", last_waits, 0);
        issue(2'b00, 16'hF0F0, 16'hFF00, 6'b000000);
        chk("b2b_ready3", last_waits, 0);
        drain();

        // Multiply.
        issue(2'b01, 16'd300, 16'd300, 6'b000000);
        wait_done();
        issue(2'b01, 16'd255, 16'd255, 6'b000000);
        wait_done();
        drain();

        // Shifts.
        issue(2'b10, 16'h8001, 16'd1, 6'b000000);
        wait_done();
        issue(2'b11, 16'h8001, 16'd17, 6'b000000);
        wait_done();
        issue(2'b10, 16'h1234, 16'd0, 6'b000000);
        chk("shl0_valid_next", out_valid, 1);
        drain();

        // Backpressure held in DONE.
        out_ready = 1'b0;
        issue(2'b00, 16'd5, 16'd7, 6'b000010);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_out", out, 16'd12);
            chk("bp_flags", {zr, ng, cy}, 3'b000);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_out_kept", out, 16'd12);
        chk("bp_sb_empty", q.size(), 0);

        // Reset at multiply iteration 8.
        issue(2'b01, 16'd300, 16'd300, 6'b000000);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out", out, 0);
        chk("mrst_flags", {zr, ng, cy}, 0);
        chk("mrst_in_ready", in_ready, 1);
        issue(2'b00, 16'd100, 16'd23, 6'b000010);
        drain();

        // Random back-to-back mix.
        for (int i = 0; i < 24; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            issue(m, 16'($urandom), (m[1] ? 16'($urandom_range(0, 40)) : 16'($urandom)),
                  6'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
